// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the APB UART slave and the UART transmitter.
// Software writes bytes with push. The drain FSM hands them to the transmitter
// one at a time over a start/busy/done handshake. A byte leaves the FIFO only
// after the transmitter has shown busy in response to its start pulse.
module uart_tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     clr_ovf,
  input  logic                     tx_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACK    = 2'd2,
    DONE   = 2'd3
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_tx_data;
  state_t            r_state;
  state_t            w_next_state;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_load;
  logic w_pop;

  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == C_EMPTY);
  // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok = push && !w_full;
  // Latch the head byte only when the transmitter is idle and draining is allowed.
  assign w_load    = (r_state == IDLE) && tx_en && !w_empty && !tx_busy;
  // The head byte is consumed only once the transmitter has shown it accepted it.
  assign w_pop     = (r_state == ACK) && tx_busy;

  // Storage array write port; contents need no reset because count guards reads.
  always_ff @(posedge PCLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Write/read pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy counter: excludes the byte already handed to the transmitter.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag; a dropped push outranks a simultaneous clear.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_overflow <= 1'b0;
    end else if (push && w_full) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // Byte presented to the transmitter; held stable from launch until the next load.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_tx_data <= '0;
    end else if (w_load) begin
      r_tx_data <= r_mem[r_rd_ptr];
    end
  end

  // Drain FSM state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Drain FSM next-state logic: launch, check acceptance, wait for frame end.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_next_state = LAUNCH;
        end else begin
          w_next_state = IDLE;
        end
      end
      LAUNCH: begin
        w_next_state = ACK;
      end
      ACK: begin
        // No busy means the transmitter refused the byte; retry from IDLE.
        if (tx_busy) begin
          w_next_state = DONE;
        end else begin
          w_next_state = IDLE;
        end
      end
      DONE: begin
        if (tx_done || !tx_busy) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign start    = (r_state == LAUNCH);
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a behavioural
// transmitter (10-bit frame, LSB first) and a queue-based scoreboard.
module tb_uart_tx_fifo;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       tx_en = 1'b0;
  logic       full, empty, overflow, start;
  logic [3:0] count;
  logic [7:0] tx_data;

  // transmitter model
  logic       m_busy, m_done, m_acc;
  logic [7:0] m_acc_byte;
  logic [9:0] m_shreg;
  logic [3:0] m_bitcnt;
  logic       tx_line;

  int n_pass = 0, n_total = 0;
  int n_start = 0, n_acc = 0, n_done = 0, n_line = 0;
  logic [7:0] exp_q[$];
  logic [7:0] line_q[$];
  logic [9:0] line_bits;
  int         line_idx = 0;
  logic [7:0] mon_e;

  uart_tx_fifo #(.DEPTH(8), .DATA_W(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .push(push), .push_data(push_data),
    .clr_ovf(clr_ovf), .tx_en(tx_en), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .start(start), .tx_data(tx_data),
    .tx_busy(m_busy), .tx_done(m_done)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transmitter: accepts a start only while enabled and idle, busy 10 cycles, then done.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_acc <= 1'b0;
      m_acc_byte <= 8'h00; m_shreg <= 10'h3FF; m_bitcnt <= 4'd0;
    end else begin
      m_done <= 1'b0;
      m_acc  <= 1'b0;
      if (start && tx_en && !m_busy) begin
        m_shreg    <= {1'b1, tx_data, 1'b0};
        m_bitcnt   <= 4'd10;
        m_busy     <= 1'b1;
        m_acc      <= 1'b1;
        m_acc_byte <= tx_data;
      end else if (m_busy) begin
        if (m_bitcnt == 4'd1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_bitcnt <= 4'd0;
        end else begin
          m_shreg  <= m_shreg >> 1;
          m_bitcnt <= m_bitcnt - 4'd1;
        end
      end
    end
  end
  assign tx_line = m_busy ? m_shreg[0] : 1'b1;

  // Monitor: compares launches, accepted bytes and deserialised line frames.
  always @(negedge PCLK) begin
    if (PRESET) begin
      line_idx = 0;
    end else begin
      if (start) begin
        n_start++;
        check("launch_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("launch_data", 32'(tx_data), 32'(exp_q[0]));
      end
      if (m_acc) begin
        n_acc++;
        check("accept_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("accept_data", 32'(m_acc_byte), 32'(mon_e));
          line_q.push_back(mon_e);
        end
      end
      if (m_done) n_done++;
      if (m_busy) begin
        line_bits[line_idx] = tx_line;
        line_idx++;
        if (line_idx == 10) begin
          line_idx = 0;
          n_line++;
          check("line_framing", 32'({line_bits[9], line_bits[0]}), 32'd2);
          if (line_q.size() > 0) check("line_byte", 32'(line_bits[8:1]), 32'(line_q.pop_front()));
          else check("line_q_nonempty", 32'd0, 32'(line_q.size() + 1));
        end
      end else begin
        line_idx = 0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input bit acc, input bit with_clr);
    @(posedge PCLK); #1;
    push = 1'b1; push_data = d; clr_ovf = with_clr;
    if (acc) exp_q.push_back(d);
    @(posedge PCLK); #1;
    push = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (empty && !m_busy && !start) begin ok = 1'b1; break; end
    end
    check("drain_in_time", 32'(ok), 32'd1);
    repeat (4) @(negedge PCLK);
  endtask

  task automatic wait_not_full(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (!full) begin ok = 1'b1; break; end
    end
    if (!ok) check("not_full_in_time", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bit ok;
    // 1: reset state, then reset with bytes queued and a frame in flight
    @(negedge PCLK);
    check_reset_state("por");
    @(posedge PCLK); #1 PRESET = 1'b0;
    tx_en = 1'b1;
    push_byte(8'h5A, 1'b1, 1'b0);
    push_byte(8'h6B, 1'b1, 1'b0);
    push_byte(8'h7C, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (n_acc >= 1) begin ok = 1'b1; break; end
    end
    check("first_accept_in_time", 32'(ok), 32'd1);
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b1;
    exp_q.delete(); line_q.delete();
    @(negedge PCLK);
    check_reset_state("midframe");
    check("midframe_busy", 32'(m_busy), 32'd0);
    @(posedge PCLK); #1 PRESET = 1'b0;
    base = n_start;
    repeat (6) @(negedge PCLK);
    check("after_reset_no_start", 32'(n_start - base), 32'd0);

    // 2: single byte latency and handshake
    push_byte(8'hA5, 1'b1, 1'b0);
    @(negedge PCLK);
    check("single_count_queued", 32'(count), 32'd1);
    check("single_no_start_yet", 32'(start), 32'd0);
    @(negedge PCLK);
    check("single_start", 32'(start), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    @(negedge PCLK);
    check("single_start_one_cycle", 32'(start), 32'd0);
    check("single_count_before_pop", 32'(count), 32'd1);
    @(negedge PCLK);
    check("single_count_after_pop", 32'(count), 32'd0);
    wait_idle(100);
    check("single_tx_data_held", 32'(tx_data), 32'hA5);

    // 3: burst of eight with drain held off, then in-order drain
    tx_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_byte(8'(i + 1), 1'b1, 1'b0);
      @(negedge PCLK);
      check("burst_count", 32'(count), 32'(i + 1));
    end
    check("burst_full", 32'(full), 32'd1);
    check("burst_overflow", 32'(overflow), 32'd0);
    base = n_acc;
    n_start = 0; n_done = 0;
    @(posedge PCLK); #1 tx_en = 1'b1;
    wait_idle(400);
    check("burst_accepted", 32'(n_acc - base), 32'd8);
    check("burst_starts", 32'(n_start), 32'd8);
    check("burst_dones", 32'(n_done), 32'd8);

    // 4: overflow and clear precedence
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'(8'h40 + i), (i < 8), 1'b0);
    @(negedge PCLK);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    @(posedge PCLK); #1 clr_ovf = 1'b1;
    @(posedge PCLK); #1 clr_ovf = 1'b0;
    @(negedge PCLK);
    check("ovf_cleared", 32'(overflow), 32'd0);
    push_byte(8'hEE, 1'b0, 1'b1);
    @(negedge PCLK);
    check("ovf_push_beats_clear", 32'(overflow), 32'd1);
    check("ovf_count_held", 32'(count), 32'd8);
    @(posedge PCLK); #1 clr_ovf = 1'b1;
    @(posedge PCLK); #1 clr_ovf = 1'b0;
    base = n_acc;
    tx_en = 1'b1;
    wait_idle(400);
    check("ovf_drained", 32'(n_acc - base), 32'd8);
    check("ovf_flag_after_drain", 32'(overflow), 32'd0);

    // 5: enable gating and refused launch retry
    tx_en = 1'b0;
    push_byte(8'h31, 1'b1, 1'b0);
    push_byte(8'h32, 1'b1, 1'b0);
    push_byte(8'h33, 1'b1, 1'b0);
    base = n_start;
    repeat (20) @(negedge PCLK);
    check("gate_no_start", 32'(n_start - base), 32'd0);
    check("gate_count", 32'(count), 32'd3);
    base = n_acc;
    @(posedge PCLK); #1 tx_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (start) begin ok = 1'b1; break; end
    end
    check("retry_start_seen", 32'(ok), 32'd1);
    tx_en = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("retry_count", 32'(count), 32'd3);
    check("retry_busy", 32'(m_busy), 32'd0);
    check("retry_no_accept", 32'(n_acc - base), 32'd0);
    repeat (10) @(negedge PCLK);
    check("retry_still_held", 32'(count), 32'd3);
    @(posedge PCLK); #1 tx_en = 1'b1;
    wait_idle(300);
    check("gate_drained", 32'(n_acc - base), 32'd3);

    // 6: interleaved push/drain across pointer wrap
    base = n_line;
    for (int i = 0; i < 20; i++) begin
      wait_not_full(300);
      push_byte(8'(8'h10 + i), 1'b1, 1'b0);
      repeat ((i % 3 == 0) ? 20 : 3) @(posedge PCLK);
    end
    wait_idle(600);
    repeat (4) @(negedge PCLK);
    check("wrap_frames", 32'(n_line - base), 32'd20);
    check("wrap_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_line_q_empty", 32'(line_q.size()), 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
